cmos_dvp_capture: RTL

- Downstream of camera_init: consumes Init_Done and the sensor DVP bus (VSYNC, HREF, 8-bit data).
- Skips the first frames after init while the sensor settles.
- Assembles byte pairs into 16-bit RGB565 pixels and produces pixel coordinates, frame start/done pulses and a per-frame geometry check.
- Output feeds the frame-buffer write path.

---
 rtl/cmos_dvp_capture.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cmos_dvp_capture.sv
// cmos_dvp_capture: DVP sensor front end. Waits for sensor configuration,
// discards settling frames, pairs bytes into RGB565 pixels with coordinates,
// and reports frame boundaries plus a per-frame geometry check.
module cmos_dvp_capture #(
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480,
  parameter int unsigned SKIP_FRAMES  = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Init_Done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        DataValid,
  output logic [15:0] DataPixel,
  output logic [11:0] X_Addr,
  output logic [11:0] Y_Addr,
  output logic        Frame_Start,
  output logic        Frame_Done,
  output logic [15:0] Frame_Cnt,
  output logic        Size_Err
);

  localparam logic [11:0] WIDTH_C     = 12'(IMAGE_WIDTH);
  localparam logic [11:0] HEIGHT_C    = 12'(IMAGE_HEIGHT);
  localparam logic [7:0]  SKIP_LAST_C = 8'(SKIP_FRAMES - 1);
  localparam bit          NO_SKIP_C   = (SKIP_FRAMES == 0);

  typedef enum logic [1:0] {WAIT_INIT, SKIP, CAPTURE} state_e;

  state_e      state_q, state_d;
  logic        vsync_r, vsync_r_d1, href_r, href_r_d1;
  logic [7:0]  data_r;
  logic        vs_rise, vs_fall, href_fall, start_ev, in_frame;
  logic [7:0]  skip_q;
  logic        active_q, pend_q, tog_q;
  logic [7:0]  hi_q;
  logic [11:0] x_q, y_q, x_inc, y_inc;
  logic        odd_q, werr_q, ovf_q;
  logic        valid_q, start_q, done_q, serr_q;
  logic [15:0] pix_q, cnt_q;
  logic [11:0] xa_q, ya_q;

  assign vs_rise   = vsync_r & ~vsync_r_d1;
  assign vs_fall   = ~vsync_r & vsync_r_d1;
  assign href_fall = ~href_r & href_r_d1;
  assign x_inc     = (x_q == 12'hFFF) ? x_q : x_q + 12'd1;
  assign y_inc     = (y_q == 12'hFFF) ? y_q : y_q + 12'd1;
  // With no settling frames the first vs_fall after init starts capture directly.
  assign start_ev  = Init_Done & vs_fall &
                     ((state_q == CAPTURE) | ((state_q == WAIT_INIT) & NO_SKIP_C));
  assign in_frame  = Init_Done & (state_q == CAPTURE) & active_q;

  assign DataValid   = valid_q;
  assign DataPixel   = pix_q;
  assign X_Addr      = xa_q;
  assign Y_Addr      = ya_q;
  assign Frame_Start = start_q;
  assign Frame_Done  = done_q;
  assign Frame_Cnt   = cnt_q;
  assign Size_Err    = serr_q;

  // Register the sensor bus once and keep one-cycle history for edge detects.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vsync_r    <= 1'b0;
      vsync_r_d1 <= 1'b0;
      href_r     <= 1'b0;
      href_r_d1  <= 1'b0;
      data_r     <= '0;
    end else begin
      vsync_r    <= cmos_vsync;
      vsync_r_d1 <= vsync_r;
      href_r     <= cmos_href;
      href_r_d1  <= href_r;
      data_r     <= cmos_data;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= WAIT_INIT;
    else        state_q <= state_d;
  end

  // Next-state: init gating and settling-frame skip.
  always_comb begin
    state_d = state_q;
    if (!Init_Done) begin
      state_d = WAIT_INIT;
    end else begin
      case (state_q)
        WAIT_INIT: begin
          if (!NO_SKIP_C)   state_d = SKIP;
          else if (vs_fall) state_d = CAPTURE;
        end
        SKIP:    if (vs_fall && skip_q == SKIP_LAST_C) state_d = CAPTURE;
        CAPTURE: state_d = CAPTURE;
        default: state_d = WAIT_INIT;
      endcase
    end
  end

  // Count settling-frame vs_fall events; cleared outside SKIP or on init loss.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                             skip_q <= '0;
    else if (!Init_Done || state_q != SKIP) skip_q <= '0;
    else if (vs_fall)                       skip_q <= skip_q + 8'd1;
  end

  // Pixel assembly, coordinates, geometry flags and frame pulses.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      active_q <= 1'b0; pend_q <= 1'b0; tog_q <= 1'b0; hi_q <= '0;
      x_q <= '0; y_q <= '0; odd_q <= 1'b0; werr_q <= 1'b0; ovf_q <= 1'b0;
      valid_q <= 1'b0; start_q <= 1'b0; done_q <= 1'b0; serr_q <= 1'b0;
      pix_q <= '0; cnt_q <= '0; xa_q <= '0; ya_q <= '0;
    end else begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (!href_r || !in_frame) tog_q <= 1'b0;
      if (!Init_Done) begin
        active_q <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        if (in_frame) begin
          if (href_r && !vsync_r) begin
            if (!tog_q) begin
              hi_q  <= data_r;
              tog_q <= 1'b1;
            end else begin
              tog_q <= 1'b0;
              x_q   <= x_inc;
              if (x_q < WIDTH_C && y_q < HEIGHT_C) begin
                valid_q <= 1'b1;
                pix_q   <= {hi_q, data_r};
                xa_q    <= x_q;
                ya_q    <= y_q;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
          if (href_fall) begin
            if (tog_q) odd_q <= 1'b1;
            if (x_q != 12'd0) begin
              if (x_q != WIDTH_C) werr_q <= 1'b1;
              y_q <= y_inc;
              x_q <= '0;
            end
          end
          // Frame end is deferred one cycle so a pixel or line end landing
          // on the vs_rise cycle is accounted for before the geometry check.
          if (vs_rise) pend_q <= 1'b1;
        end
        if (pend_q) begin
          done_q   <= 1'b1;
          cnt_q    <= cnt_q + 16'd1;
          serr_q   <= (y_q != HEIGHT_C) | odd_q | werr_q | ovf_q;
          active_q <= 1'b0;
          pend_q   <= 1'b0;
        end
        if (start_ev) begin
          start_q  <= 1'b1;
          active_q <= 1'b1;
          tog_q    <= 1'b0;
          x_q      <= '0;
          y_q      <= '0;
          odd_q    <= 1'b0;
          werr_q   <= 1'b0;
          ovf_q    <= 1'b0;
        end
      end
    end
  end

endmodule
